serial_bus_arbiter: RTL and testbench
=====================================

Name: serial_bus_arbiter

Overview:
- Controls the shared serial interconnect between two masters (m1, m2) and three slaves (s1..s3).
- Arbitrates bus ownership and captures the serial slave address from the granted master's tx line.
- Drives the master-select and one-hot slave-select controls consumed by the bus mux.
- Handles split transactions when s1 is busy, and force-releases a stalled owner after a timeout.

Parameters:
ADDR_W, 2, width of serial slave address sent MSB-first after grant
TIMEOUT_W, 10, width of ownership watchdog counter; timeout = 2**TIMEOUT_W-1 cycles in CONNECT

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
m1_req  input  1  master 1 requests/holds bus; drop ends transfer
m2_req  input  1  master 2 requests/holds bus
mtx  input  1  serial tx line of currently granted master (post-mux)
s1_busy  input  1  slave 1 cannot accept a transfer
m1_grant  output  1  master 1 owns bus
m2_grant  output  1  master 2 owns bus
msel  output  1  mux select, 0=m1, 1=m2; valid while any grant high
ssel  output  3  one-hot slave select {s3,s2,s1}; nonzero only in CONNECT
m1_split  output  1  1-cycle pulse: m1 transfer split, retry later
m2_split  output  1  1-cycle pulse: m2 transfer split
addr_err  output  1  1-cycle pulse: decoded address >= 3
timeout  output  1  1-cycle pulse: watchdog forced release

Behaviour:
- Reset (async, rst=1): state IDLE; all grants, ssel, pulses = 0; msel=0; split record cleared; counters 0.
- States: IDLE, ADDR, CONNECT, RELEASE.
- IDLE: if split record set, s1_busy=0 and split master still requesting -> grant that master (overrides priority), clear record. Else fixed priority m1 > m2. Grant asserted cycle after req seen; msel set same edge. Go ADDR.
- ADDR: shift mtx in MSB-first, one bit per cycle, ADDR_W cycles starting first cycle grant is high. On last bit, decode:
  - addr 0/1/2 -> s1/s2/s3. If target s1 and s1_busy=1 that cycle -> pulse mX_split, set split record (master id), drop grant -> RELEASE.
  - addr >= 3 -> pulse addr_err, drop grant -> RELEASE.
  - else -> CONNECT with ssel set on the same edge.
- CONNECT: hold grant/msel/ssel. Owner req=0 -> drop grant, ssel=0 -> RELEASE. Watchdog increments each cycle; at all-ones pulse timeout, drop grant -> RELEASE. s1_busy rising during CONNECT is ignored.
- RELEASE: one idle cycle, no grant (bus turnaround) -> IDLE.
- Owner dropping req during ADDR: abort, no pulse -> RELEASE.
- Split record holds one master only. A second split (other master) while the record is set: new split pulses, but record keeps the first master.
- Split master dropping req before resume: record cleared in IDLE.
- Grants are mutually exclusive at all times; never both high.
- Reset mid-transfer: immediate return to reset values; no pulses emitted.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: IDLE priority alternates; the master granted last has lowest priority on the next simultaneous request. Split-resume still overrides. Last-owner bit resets to m2 so m1 wins first.
- Undefined: fixed m1 > m2 priority.

Decomposition:
- Package serial_bus_pkg:
  - arb_state_t enum (IDLE, ADDR, CONNECT, RELEASE)
  - slave id constants SLV_S1=0, SLV_S2=1, SLV_S3=2
  - NUM_SLAVES=3
  - master id type
- Sub-module bus_addr_capture: ADDR_W shift register + bit counter. Inputs start/abort; outputs addr and done pulse.

Test Plan:
- m1_req=1, mtx sends 2'b01 -> m1_grant at cycle 1; ssel=3'b010 after 2 address cycles; m1_req=0 -> grant low next cycle, one RELEASE cycle.
- m1_req and m2_req rise same cycle, fixed priority -> m1 granted. With ARB_ROUND_ROBIN_EN, repeat twice -> m1 then m2.
- m2 addresses 2'b00 with s1_busy=1 -> m2_split pulse, grant dropped. m1 then served to s3. s1_busy=0 with m2_req held -> m2 granted before a pending m1_req.
- mtx sends 2'b11 -> addr_err single pulse, no ssel, grant dropped, IDLE after RELEASE.
- m1 holds req in CONNECT for 1023 cycles -> timeout pulse, m1_grant=0; m2 pending -> m2 granted after RELEASE.
- Assert rst mid-CONNECT -> grants, ssel, msel zero asynchronously; no split/err pulses after release.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared types and constants for the two-master / three-slave serial bus arbiter.
package serial_bus_pkg;

  localparam int unsigned NUM_SLAVES = 3;
  localparam int unsigned SLV_S1     = 0;
  localparam int unsigned SLV_S2     = 1;
  localparam int unsigned SLV_S3     = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    CONNECT = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // Master id doubles as the mux select encoding (0=m1, 1=m2)
  typedef enum logic {
    MST_M1 = 1'b0,
    MST_M2 = 1'b1
  } mst_id_t;

  // Pending split transaction: which master must be resumed once s1 frees up
  typedef struct packed {
    logic    vld;
    mst_id_t mst;
  } split_rec_t;

  // Request line of the given master
  function automatic logic mst_req(input mst_id_t m, input logic r1, input logic r2);
    return (m == MST_M1) ? r1 : r2;
  endfunction

endpackage

// File: rtl/serial_bus_arbiter_if.sv
// Arbiter control bundle: master requests/tx line in, grants/selects/status pulses out.
interface serial_bus_arbiter_if;
  import serial_bus_pkg::*;

  logic                  m1_req;
  logic                  m2_req;
  logic                  mtx;
  logic                  s1_busy;
  logic                  m1_grant;
  logic                  m2_grant;
  logic                  msel;
  logic [NUM_SLAVES-1:0] ssel;
  logic                  m1_split;
  logic                  m2_split;
  logic                  addr_err;
  logic                  timeout;

  // Arbiter side
  modport slave (
    input  m1_req, m2_req, mtx, s1_busy,
    output m1_grant, m2_grant, msel, ssel, m1_split, m2_split, addr_err, timeout
  );

  // Requester / environment side
  modport master (
    output m1_req, m2_req, mtx, s1_busy,
    input  m1_grant, m2_grant, msel, ssel, m1_split, m2_split, addr_err, timeout
  );

endinterface

// File: rtl/serial_bus_arbiter_addr_capture.sv
// Serial slave-address capture: MSB-first shift register plus bit counter.
// addr_c/done_c are combinational so the arbiter can decode on the last-bit edge.
module bus_addr_capture #(
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              bit_i,
  output logic [ADDR_W-1:0] addr_c,
  output logic              done_c
);

  localparam int unsigned SH_W  = ADDR_W - 1;
  localparam int unsigned CNT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

  logic [SH_W-1:0]  sh_q;
  logic [CNT_W-1:0] cnt_q;
  logic             active_q;

  assign addr_c = {sh_q, bit_i};
  assign done_c = active_q && (cnt_q == CNT_W'(ADDR_W - 1));

  // Shift one bit per cycle while active; start/abort re-arm or stop the capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i || abort_i) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      active_q <= start_i;
    end else if (active_q) begin
      sh_q <= addr_c[SH_W-1:0];
      if (done_c) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/serial_bus_arbiter.sv
// Serial bus arbiter for masters m1/m2 and slaves s1..s3: grants ownership,
// captures the slave address, drives msel/ssel, handles s1 splits and a
// CONNECT watchdog. Define ARB_ROUND_ROBIN_EN for alternating priority.
module serial_bus_arbiter
  import serial_bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  serial_bus_arbiter_if.slave bus
);

  // Watchdog fires on the edge where the counter would reach all-ones
  localparam logic [TIMEOUT_W-1:0] WD_LAST  = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0]    ADDR_S1  = ADDR_W'(SLV_S1);
  localparam logic [ADDR_W-1:0]    ADDR_LIM = ADDR_W'(NUM_SLAVES);

  logic m1_req, m2_req, s1_busy;
  assign m1_req  = bus.m1_req;
  assign m2_req  = bus.m2_req;
  assign s1_busy = bus.s1_busy;

  arb_state_t            state_q, state_d;
  logic                  m1_grant_q, m1_grant_d, m2_grant_q, m2_grant_d;
  mst_id_t               msel_q, msel_d;
  logic [NUM_SLAVES-1:0] ssel_q, ssel_d;
  logic                  m1_split_q, m1_split_d, m2_split_q, m2_split_d;
  logic                  addr_err_q, addr_err_d, timeout_q, timeout_d;
  split_rec_t            split_q, split_d;
  logic [TIMEOUT_W-1:0]  wd_q, wd_d;
`ifdef ARB_ROUND_ROBIN_EN
  mst_id_t               last_q, last_d;
`endif

  logic                  owner_req_c, pick_vld_c, cap_start_c, cap_abort_c, cap_done_c;
  mst_id_t               pick_c;
  logic [ADDR_W-1:0]     cap_addr_c;

  assign owner_req_c = mst_req(msel_q, m1_req, m2_req);

  bus_addr_capture #(.ADDR_W(ADDR_W)) u_cap (
    .clk     (clk),
    .rst     (rst),
    .start_i (cap_start_c),
    .abort_i (cap_abort_c),
    .bit_i   (bus.mtx),
    .addr_c  (cap_addr_c),
    .done_c  (cap_done_c)
  );

  // Next-state, grant/select and status-pulse logic
  always_comb begin
    state_d     = state_q;
    m1_grant_d  = m1_grant_q;
    m2_grant_d  = m2_grant_q;
    msel_d      = msel_q;
    ssel_d      = ssel_q;
    m1_split_d  = 1'b0;
    m2_split_d  = 1'b0;
    addr_err_d  = 1'b0;
    timeout_d   = 1'b0;
    split_d     = split_q;
    wd_d        = wd_q;
    pick_vld_c  = 1'b0;
    pick_c      = MST_M1;
    cap_start_c = 1'b0;
    cap_abort_c = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    case (state_q)
      IDLE: begin
        pick_vld_c = 1'b1;
        if (split_q.vld && mst_req(split_q.mst, m1_req, m2_req) && !s1_busy) begin
          pick_c  = split_q.mst;
          split_d = '0;
        end else begin
          if (split_q.vld && !mst_req(split_q.mst, m1_req, m2_req)) split_d = '0;
          if (m1_req && m2_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            pick_c = (last_q == MST_M1) ? MST_M2 : MST_M1;
`else
            pick_c = MST_M1;
`endif
          end else if (m1_req) pick_c = MST_M1;
          else if (m2_req)     pick_c = MST_M2;
          else                 pick_vld_c = 1'b0;
        end
        if (pick_vld_c) begin
          state_d     = ADDR;
          m1_grant_d  = (pick_c == MST_M1);
          m2_grant_d  = (pick_c == MST_M2);
          msel_d      = pick_c;
          cap_start_c = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_d      = pick_c;
`endif
        end
      end
      ADDR: begin
        if (!owner_req_c) begin
          cap_abort_c = 1'b1;
          m1_grant_d  = 1'b0;
          m2_grant_d  = 1'b0;
          state_d     = RELEASE;
        end else if (cap_done_c) begin
          if (cap_addr_c >= ADDR_LIM) begin
            addr_err_d = 1'b1;
            m1_grant_d = 1'b0;
            m2_grant_d = 1'b0;
            state_d    = RELEASE;
          end else if ((cap_addr_c == ADDR_S1) && s1_busy) begin
            m1_split_d = (msel_q == MST_M1);
            m2_split_d = (msel_q == MST_M2);
            if (!split_q.vld) begin
              split_d.vld = 1'b1;
              split_d.mst = msel_q;
            end
            m1_grant_d = 1'b0;
            m2_grant_d = 1'b0;
            state_d    = RELEASE;
          end else begin
            ssel_d  = NUM_SLAVES'(1) << cap_addr_c;
            wd_d    = '0;
            state_d = CONNECT;
          end
        end
      end
      CONNECT: begin
        if (!owner_req_c || (wd_q == WD_LAST)) begin
          timeout_d  = owner_req_c;
          m1_grant_d = 1'b0;
          m2_grant_d = 1'b0;
          ssel_d     = '0;
          wd_d       = '0;
          state_d    = RELEASE;
        end else begin
          wd_d = wd_q + TIMEOUT_W'(1);
        end
      end
      RELEASE: begin
        wd_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      m1_grant_q <= 1'b0;
      m2_grant_q <= 1'b0;
      msel_q     <= MST_M1;
      ssel_q     <= '0;
      m1_split_q <= 1'b0;
      m2_split_q <= 1'b0;
      addr_err_q <= 1'b0;
      timeout_q  <= 1'b0;
      split_q    <= '0;
      wd_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= MST_M2;
`endif
    end else begin
      state_q    <= state_d;
      m1_grant_q <= m1_grant_d;
      m2_grant_q <= m2_grant_d;
      msel_q     <= msel_d;
      ssel_q     <= ssel_d;
      m1_split_q <= m1_split_d;
      m2_split_q <= m2_split_d;
      addr_err_q <= addr_err_d;
      timeout_q  <= timeout_d;
      split_q    <= split_d;
      wd_q       <= wd_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign bus.m1_grant = m1_grant_q;
  assign bus.m2_grant = m2_grant_q;
  assign bus.msel     = msel_q;
  assign bus.ssel     = ssel_q;
  assign bus.m1_split = m1_split_q;
  assign bus.m2_split = m2_split_q;
  assign bus.addr_err = addr_err_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Directed bench for serial_bus_arbiter. Observed vector layout:
// {m1_grant, m2_grant, msel, ssel[2:0], m1_split, m2_split, addr_err, timeout}
module tb_serial_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [9:0] want;

  serial_bus_arbiter_if bus_if ();

  serial_bus_arbiter #(.ADDR_W(2), .TIMEOUT_W(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] obs();
    return {bus_if.m1_grant, bus_if.m2_grant, bus_if.msel, bus_if.ssel,
            bus_if.m1_split, bus_if.m2_split, bus_if.addr_err, bus_if.timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus_if.m1_req = 1'b0; bus_if.m2_req = 1'b0; bus_if.mtx = 1'b0; bus_if.s1_busy = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    want = 10'b0_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL reset_values got %b want %b", obs(), want); end
    rst = 1'b0;
    tick();
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL reset_idle got %b want %b", obs(), want); end
  endtask

  task automatic test_basic();
    bus_if.m1_req = 1'b1; bus_if.mtx = 1'b0;
    tick();
    want = 10'b1_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL basic_grant got %b want %b", obs(), want); end
    tick();
    want = 10'b1_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL basic_addr_bit1 got %b want %b", obs(), want); end
    bus_if.mtx = 1'b1;
    tick();
    want = 10'b1_0_0_010_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL basic_connect got %b want %b", obs(), want); end
    bus_if.s1_busy = 1'b1;
    tick();
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL basic_busy_ignored got %b want %b", obs(), want); end
    bus_if.s1_busy = 1'b0; bus_if.m1_req = 1'b0; bus_if.m2_req = 1'b1;
    tick();
    want = 10'b0_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL basic_release got %b want %b", obs(), want); end
    tick();
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL basic_turnaround got %b want %b", obs(), want); end
    tick();
    want = 10'b0_1_1_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL basic_next_grant got %b want %b", obs(), want); end
    idle_all();
  endtask

  task automatic test_priority();
    bus_if.m1_req = 1'b1; bus_if.m2_req = 1'b1; bus_if.mtx = 1'b0;
    tick();
    want = 10'b1_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL prio_first got %b want %b", obs(), want); end
    bus_if.m1_req = 1'b0; bus_if.m2_req = 1'b0;
    tick();
    want = 10'b0_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL prio_abort_no_pulse got %b want %b", obs(), want); end
    repeat (2) tick();
    bus_if.m1_req = 1'b1; bus_if.m2_req = 1'b1;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    want = 10'b0_1_1_000_0_0_0_0;
`else
    want = 10'b1_0_0_000_0_0_0_0;
`endif
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL prio_second got %b want %b", obs(), want); end
    idle_all();
  endtask

  task automatic test_split();
    bus_if.s1_busy = 1'b1; bus_if.m2_req = 1'b1; bus_if.mtx = 1'b0;
    tick();
    want = 10'b0_1_1_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL split_grant got %b want %b", obs(), want); end
    tick();
    bus_if.m1_req = 1'b1;
    tick();
    want = 10'b0_0_1_000_0_1_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL split_pulse got %b want %b", obs(), want); end
    bus_if.mtx = 1'b1;
    tick();
    want = 10'b0_0_1_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL split_pulse_once got %b want %b", obs(), want); end
    tick();
    want = 10'b1_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL split_other_served got %b want %b", obs(), want); end
    tick();
    bus_if.mtx = 1'b0;
    tick();
    want = 10'b1_0_0_100_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL split_other_s3 got %b want %b", obs(), want); end
    bus_if.m1_req = 1'b0;
    tick();
    bus_if.m1_req = 1'b1; bus_if.s1_busy = 1'b0;
    repeat (2) tick();
    want = 10'b0_1_1_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL split_resume got %b want %b", obs(), want); end
    repeat (2) tick();
    want = 10'b0_1_1_001_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL split_resume_s1 got %b want %b", obs(), want); end
    idle_all();
  endtask

  task automatic test_double_split();
    bus_if.s1_busy = 1'b1; bus_if.m2_req = 1'b1; bus_if.mtx = 1'b0;
    repeat (2) tick();
    bus_if.m1_req = 1'b1;
    tick();
    want = 10'b0_0_1_000_0_1_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL dsplit_first got %b want %b", obs(), want); end
    repeat (2) tick();
    want = 10'b1_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL dsplit_m1_grant got %b want %b", obs(), want); end
    repeat (2) tick();
    want = 10'b0_0_0_000_1_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL dsplit_second_pulse got %b want %b", obs(), want); end
    bus_if.s1_busy = 1'b0;
    repeat (2) tick();
    want = 10'b0_1_1_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL dsplit_record_kept got %b want %b", obs(), want); end
    idle_all();
  endtask

  task automatic test_split_drop();
    bus_if.s1_busy = 1'b1; bus_if.m2_req = 1'b1; bus_if.mtx = 1'b0;
    repeat (3) tick();
    bus_if.m2_req = 1'b0;
    want = 10'b0_0_1_000_0_1_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL sdrop_pulse got %b want %b", obs(), want); end
    repeat (2) tick();
    bus_if.s1_busy = 1'b0; bus_if.m1_req = 1'b1; bus_if.m2_req = 1'b1;
    tick();
    want = 10'b1_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL sdrop_record_cleared got %b want %b", obs(), want); end
    idle_all();
  endtask

  task automatic test_addr_err();
    bus_if.m1_req = 1'b1; bus_if.mtx = 1'b1;
    repeat (3) tick();
    want = 10'b0_0_0_000_0_0_1_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL aerr_pulse got %b want %b", obs(), want); end
    bus_if.m1_req = 1'b0; bus_if.m2_req = 1'b1;
    tick();
    want = 10'b0_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL aerr_once got %b want %b", obs(), want); end
    tick();
    want = 10'b0_1_1_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL aerr_idle_after_release got %b want %b", obs(), want); end
    idle_all();
  endtask

  task automatic test_timeout();
    bus_if.m1_req = 1'b1; bus_if.mtx = 1'b0;
    repeat (2) tick();
    bus_if.mtx = 1'b1;
    tick();
    bus_if.m2_req = 1'b1;
    want = 10'b1_0_0_010_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL to_connect got %b want %b", obs(), want); end
    repeat (1022) tick();
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL to_before got %b want %b", obs(), want); end
    tick();
    want = 10'b0_0_0_000_0_0_0_1; checks++;
    if (obs() !== want) begin errors++; $display("FAIL to_pulse got %b want %b", obs(), want); end
    bus_if.m1_req = 1'b0;
    tick();
    want = 10'b0_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL to_once got %b want %b", obs(), want); end
    tick();
    want = 10'b0_1_1_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL to_m2_granted got %b want %b", obs(), want); end
    idle_all();
  endtask

  task automatic test_reset_mid();
    bus_if.m2_req = 1'b1; bus_if.mtx = 1'b1;
    repeat (2) tick();
    bus_if.mtx = 1'b0;
    tick();
    want = 10'b0_1_1_100_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL rmid_connect got %b want %b", obs(), want); end
    #2;
    rst = 1'b1; bus_if.s1_busy = 1'b1;
    #1;
    want = 10'b0_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL rmid_async got %b want %b", obs(), want); end
    repeat (2) tick();
    rst = 1'b0; bus_if.m2_req = 1'b0; bus_if.s1_busy = 1'b0;
    tick();
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL rmid_after got %b want %b", obs(), want); end
    tick();
    checks++;
    if (obs() !== want) begin errors++; $display("FAIL rmid_quiet got %b want %b", obs(), want); end
    bus_if.m1_req = 1'b1; bus_if.m2_req = 1'b1;
    tick();
    want = 10'b1_0_0_000_0_0_0_0; checks++;
    if (obs() !== want) begin errors++; $display("FAIL rmid_regrant got %b want %b", obs(), want); end
    idle_all();
  endtask

  initial begin
    bus_if.m1_req = 1'b0; bus_if.m2_req = 1'b0; bus_if.mtx = 1'b0; bus_if.s1_busy = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_split();
    test_double_split();
    test_split_drop();
    test_addr_err();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
